lfsr_sequence_checker: RTL

Serial checker for the bit stream produced by the team's Galois-form auto-LFSR generator. The generator emits its last stage `Y[Length]` once per cycle; this block sits at the receiving end. It self-synchronizes to that stream without knowing the generator's seed, declares lock, and then free-runs a local reference. It flags and counts bit errors and drops lock on an excessive error rate.

---
 rtl/lfsr_pkg.sv | 22 ++
 rtl/lfsr_predict.sv | 28 ++
 rtl/lfsr_sequence_checker.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants for the Galois auto-LFSR generator and its sequence checker.
// Keeping the default length and tap vector here means both ends of the link
// are built from one definition.
package lfsr_pkg;

    // Default LFSR length and [1:Length] tap vector (bit [Length] unused).
    localparam int             DEF_LENGTH = 8;
    localparam logic [1:8]     DEF_TAP    = 8'b1100_1111;

    // Checker FSM encoding.
    localparam logic [1:0]     ST_HUNT    = 2'd0;
    localparam logic [1:0]     ST_TRAIN   = 2'd1;
    localparam logic [1:0]     ST_LOCKED  = 2'd2;

    // Counter width able to hold values 0..max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/lfsr_predict.sv
// Combinational next-bit predictor for the Galois LFSR output stream.
// hist_i[1] is the newest received bit, hist_i[Length] the oldest; the
// prediction is the generator's output recurrence over that history.
module lfsr_predict
    import lfsr_pkg::*;
#(
    parameter int               Length          = DEF_LENGTH,
    parameter logic [1:Length]  Tap_Coefficient = DEF_TAP
) (
    input  logic [1:Length] hist_i,
    output logic            pred_o,
    output logic            zero_o
);

    logic acc_s;

    // Fold the tapped history bits onto the oldest bit to form the prediction.
    always_comb begin
        acc_s = hist_i[Length];
        for (int j = 1; j < Length; j++) begin
            acc_s = acc_s ^ (Tap_Coefficient[j] & hist_i[j]);
        end
    end

    assign pred_o = acc_s;
    assign zero_o = ~|hist_i;

endmodule

// File: rtl/lfsr_sequence_checker.sv
// Receive-side checker for the Galois auto-LFSR bit stream.
// HUNT fills the history, TRAIN demands a run of correct predictions on a
// non-zero history, LOCKED free-runs the reference and counts bit errors,
// dropping back to HUNT when one window collects too many errors.
module lfsr_sequence_checker
    import lfsr_pkg::*;
#(
    parameter int               Length          = DEF_LENGTH,
    parameter logic [1:Length]  Tap_Coefficient = DEF_TAP,
    parameter int               Lock_Count      = 16,
    parameter int               Window          = 32,
    parameter int               Loss_Errors     = 4,
    parameter int               Err_Width       = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Bit_In,
    input  logic                  Bit_Valid,
    input  logic                  Clear_Count,
    output logic                  Locked,
    output logic                  Error,
    output logic [Err_Width-1:0]  Error_Count
);

    localparam int FILL_W = cnt_width(Length);
    localparam int RUN_W  = cnt_width(Lock_Count);
    localparam int WIN_W  = cnt_width(Window - 1);
    localparam int WERR_W = cnt_width(Loss_Errors);

    logic [1:0]           state_q,  state_d;
    logic [1:Length]      hist_q,   hist_d;
    logic [FILL_W-1:0]    fill_q,   fill_d;
    logic [RUN_W-1:0]     run_q,    run_d;
    logic [WIN_W-1:0]     win_q,    win_d;
    logic [WERR_W-1:0]    werr_q,   werr_d;
    logic [Err_Width-1:0] cnt_q,    cnt_d;
    logic                 locked_q, locked_d;
    logic                 error_q,  error_d;

    logic                 pred_s;
    logic                 zero_s;
    logic                 count_err_s;
    logic [WERR_W-1:0]    werr_inc_s;
    logic                 win_wrap_s;

    lfsr_predict #(
        .Length          (Length),
        .Tap_Coefficient (Tap_Coefficient)
    ) u_predict (
        .hist_i (hist_q),
        .pred_o (pred_s),
        .zero_o (zero_s)
    );

    assign win_wrap_s = (win_q == WIN_W'(Window - 1));

    // Next-state logic: FSM, history shift, run/window counters, error accounting.
    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        run_d       = run_q;
        win_d       = win_q;
        werr_d      = werr_q;
        error_d     = 1'b0;
        count_err_s = 1'b0;
        werr_inc_s  = werr_q;

        if (Bit_Valid) begin
            case (state_q)
                ST_HUNT: begin
                    hist_d = {Bit_In, hist_q[1:Length-1]};
                    if (fill_q == FILL_W'(Length - 1)) begin
                        state_d = ST_TRAIN;
                        fill_d  = '0;
                        run_d   = '0;
                    end else begin
                        fill_d  = fill_q + FILL_W'(1);
                    end
                end
                ST_TRAIN: begin
                    hist_d = {Bit_In, hist_q[1:Length-1]};
                    // An all-zero history predicts zero forever, so it never builds a run.
                    if ((Bit_In == pred_s) && !zero_s) begin
                        if (run_q == RUN_W'(Lock_Count - 1)) begin
                            state_d = ST_LOCKED;
                            run_d   = '0;
                            win_d   = '0;
                            werr_d  = '0;
                        end else begin
                            run_d   = run_q + RUN_W'(1);
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                ST_LOCKED: begin
                    // Shift the prediction, not the received bit, so one channel
                    // error cannot corrupt later predictions.
                    hist_d = {pred_s, hist_q[1:Length-1]};
                    if (Bit_In != pred_s) begin
                        error_d     = 1'b1;
                        count_err_s = 1'b1;
                        werr_inc_s  = werr_q + WERR_W'(1);
                    end else begin
                        werr_inc_s  = werr_q;
                    end
                    win_d = win_wrap_s ? '0 : (win_q + WIN_W'(1));
                    if (werr_inc_s == WERR_W'(Loss_Errors)) begin
                        state_d = ST_HUNT;
                        fill_d  = '0;
                        werr_d  = '0;
                    end else if (win_wrap_s) begin
                        werr_d  = '0;
                    end else begin
                        werr_d  = werr_inc_s;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    fill_d  = '0;
                    run_d   = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        // A clear on the same edge as a counted error takes priority.
        if (Clear_Count) begin
            cnt_d = '0;
        end else if (count_err_s && !(&cnt_q)) begin
            cnt_d = cnt_q + Err_Width'(1);
        end else begin
            cnt_d = cnt_q;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // State, history, counters and registered outputs with async active-low reset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_HUNT;
            hist_q   <= '0;
            fill_q   <= '0;
            run_q    <= '0;
            win_q    <= '0;
            werr_q   <= '0;
            cnt_q    <= '0;
            locked_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            run_q    <= run_d;
            win_q    <= win_d;
            werr_q   <= werr_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            error_q  <= error_d;
        end
    end

    assign Locked      = locked_q;
    assign Error       = error_q;
    assign Error_Count = cnt_q;

endmodule
